dv_stimulus: RTL and testbench
==============================

// Module: dv_stimulus
// PURPOSE
//  Testbench stimulus sequencer. Holds a preloaded table of transactions and
//  replays it into the DUT once the test start level goes high. Each entry
//  carries a per-entry idle delay. Replay obeys emesh-style access/wait flow
//  control. stim_done is raised when the table is exhausted and feeds the
//  test controller's end-of-simulation logic.
// PARAMETERS
//  PW     104  packet width in bits
//  DEPTH  256  table entries
//  AW     8    table address width; must equal log2(DEPTH)
//  DW     16   delay field width
// PORTS
//  clk          in   1         single clock; all logic on posedge
//  nreset       in   1         reset, asynchronous, active-low
//  start        in   1         level; replay begins while high in IDLE
//  load_en      in   1         table write strobe; honoured only in IDLE
//  load_addr    in   AW        table write address
//  load_data    in   PW+DW+1   entry: {vld, delay[DW-1:0], packet[PW-1:0]}
//  stim_wait    in   1         DUT backpressure; holds the current access
//  stim_access  out  1         packet valid
//  stim_packet  out  PW        packet payload
//  stim_done    out  1         sticky; table exhausted
//  stim_count   out  AW+1      number of accepted packets
// BEHAVIOUR
//  Reset: state=IDLE, addr=0, stim_access=0, stim_packet=0, stim_done=0,
//   stim_count=0. Table contents are not reset.
//  FSM states: IDLE, FETCH, EVAL, WAIT, SEND, DONE.
//  IDLE: start=1 -> FETCH. start is sampled only in IDLE; later drops are ignored.
//  FETCH: issue a synchronous read of table[addr]. Data is valid in EVAL.
//  EVAL transitions:
//   - vld=0 -> DONE (terminator entry).
//   - delay=0 -> SEND.
//   - otherwise -> WAIT, with cnt=delay.
//  WAIT: cnt decrements each cycle; cnt==1 -> SEND. This gives exactly
//   `delay` cycles in WAIT.
//  SEND: stim_access=1 and stim_packet=entry payload, both registered and
//   held stable while stim_wait=1.
//   - Accept condition: stim_access & ~stim_wait.
//   - On accept: stim_count+1, addr+1, stim_access drops next cycle.
//   - Next state: addr==DEPTH-1 -> DONE (no wrap); else -> FETCH.
//  Zero-delay entries therefore issue at best one access every 3 cycles.
//  DONE: stim_access=0, stim_done=1 until nreset. start has no effect.
//  Writes: load_en outside IDLE is dropped. A write in the same cycle as the
//   IDLE->FETCH transition still completes.
//  Reset mid-replay: the next access restarts from entry 0; the table survives.
//  stim_count saturates at DEPTH.
// CONFIGURATION
//  CFG_STIM_THROTTLE_EN defined:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset,
//     advancing every cycle.
//   - EVAL adds lfsr[3:0] to delay; an effective delay of 0 still goes
//     straight to SEND.
//  CFG_STIM_THROTTLE_EN undefined: delays are exactly as in the table; no LFSR.
// STRUCTURE
//  Shared include dv_stim_defines.vh holds:
//   - state encodings (3 bits);
//   - entry field offsets (VLD_BIT, DLY_LSB, PKT_LSB);
//   - LFSR seed and tap constants.
//  Sub-module dv_stim_mem: single-port RAM, DEPTH x (PW+DW+1), synchronous
//   read, write-first. Write port is muxed between load_* and the idle path.
//  Top level holds the FSM, delay counter, address/count registers and the
//   optional LFSR.
// TESTING
//  1. Load 3 entries with delay=0 and packets 1,2,3, then a vld=0
//     terminator. start=1 -> three accesses, 3 cycles apart, payloads 1,2,3;
//     stim_count=3; stim_done=1 two cycles after the 3rd accept.
//  2. Entry with delay=5, packet 0xAB -> access asserts exactly 5 cycles
//     after EVAL. Measure start-rise to access = 8 cycles.
//  3. stim_wait=1 for 4 cycles during SEND -> access and packet held stable
//     for 4 cycles; one accept only; stim_count increments by 1.
//  4. Fill all 256 entries vld=1, delay=0 -> 256 accepts, stim_count=256,
//     stim_done=1; addr does not wrap and no 257th access occurs.
//  5. nreset pulse after the 2nd accept of scenario 1, then start=1 ->
//     replay again from packet 1; all outputs at reset values during reset.
//  6. With CFG_STIM_THROTTLE_EN, rerun scenario 1 -> gaps equal
//     3 + lfsr[3:0] per model; payload order unchanged; stim_count=3.

Source files
------------

// File: rtl/dv_stimulus_pkg.sv
// dv_stimulus_pkg -- shared definitions for the stimulus sequencer: FSM state
// encoding, default table geometry and the throttle LFSR constants.
package dv_stimulus_pkg;

    localparam int DEF_PW    = 104;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci register sit on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/dv_stim_mem.sv
// dv_stim_mem -- single-port transaction table with synchronous, write-first
// read. The read register holds its value whenever the port is idle, so the
// sequencer can keep using the fetched entry across its wait period.
module dv_stim_mem #(
    parameter int W     = 121,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Table write and synchronous read; a write also returns the new data.
    // NOTE: the storage array has no reset; contents survive nreset by design
    // and a reset loop would also stop the array mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dv_stimulus.sv
// dv_stimulus -- replays a preloaded transaction table onto an emesh-style
// access/wait interface once start is seen in IDLE. Each entry is
// {vld, delay, packet}; vld=0 terminates the replay, delay inserts idle
// cycles before the access. stim_done is sticky until nreset.
// Optional build macro CFG_STIM_THROTTLE_EN adds a free-running 16-bit LFSR
// whose low nibble is added to every entry delay.
module dv_stimulus
    import dv_stimulus_pkg::*;
#(
    parameter int PW    = DEF_PW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           start,
    input  logic           load_en,
    input  logic [AW-1:0]  load_addr,
    input  logic [PW+DW:0] load_data,
    input  logic           stim_wait,
    output logic           stim_access,
    output logic [PW-1:0]  stim_packet,
    output logic           stim_done,
    output logic [AW:0]    stim_count
);

    localparam int EW      = PW + DW + 1;
    localparam int VLD_BIT = PW + DW;
    localparam int DLY_LSB = PW;
    localparam int PKT_LSB = 0;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(DEPTH);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] addr;
    logic [DW:0]   cnt;
    logic [DW:0]   eff_dly;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [EW-1:0] rd_data;

    logic          ent_vld;
    logic [DW-1:0] ent_dly;
    logic [PW-1:0] ent_pkt;

    logic          accept;
    logic          at_last;
    logic          enter_send;
    logic          enter_done;
    logic          cnt_load;
    logic          cnt_dec;

    // Loads are only honoured in IDLE, which includes the cycle in which
    // start moves the FSM to FETCH; reads happen only in FETCH.
    assign mem_we   = load_en && (state == ST_IDLE);
    assign mem_en   = mem_we || (state == ST_FETCH);
    assign mem_addr = mem_we ? load_addr : addr;

    dv_stim_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (load_data),
        .rdata (rd_data)
    );

    assign ent_vld = rd_data[VLD_BIT];
    assign ent_dly = rd_data[DLY_LSB +: DW];
    assign ent_pkt = rd_data[PKT_LSB +: PW];

    assign accept  = stim_access && !stim_wait;
    assign at_last = (addr == LAST_ADDR);

`ifdef CFG_STIM_THROTTLE_EN
    logic [15:0] lfsr;

    // Free-running throttle LFSR, advancing every cycle out of reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign eff_dly = {1'b0, ent_dly} + (DW + 1)'(lfsr[3:0]);
`else
    assign eff_dly = {1'b0, ent_dly};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    // NOTE: next_state is defaulted before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_FETCH;
            ST_FETCH: next_state = ST_EVAL;
            ST_EVAL: begin
                if (!ent_vld) begin
                    next_state = ST_DONE;
                end else if (eff_dly == '0) begin
                    next_state = ST_SEND;
                end else begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT:  if (cnt == (DW + 1)'(1)) next_state = ST_SEND;
            ST_SEND: begin
                if (accept) begin
                    next_state = at_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE:  next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath registers.
    always_comb begin
        enter_send = 1'b0;
        enter_done = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_EVAL: begin
                if (!ent_vld) begin
                    enter_done = 1'b1;
                end else if (eff_dly == '0) begin
                    enter_send = 1'b1;
                end else begin
                    cnt_load   = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt == (DW + 1)'(1)) enter_send = 1'b1;
            end
            ST_SEND: begin
                if (accept && at_last) enter_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Idle-delay counter: loaded in EVAL, counts down through WAIT.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (cnt_load) begin
            cnt <= eff_dly;
        end else if (cnt_dec) begin
            cnt <= cnt - (DW + 1)'(1);
        end
    end

    // Registered access/packet: raised on entry to SEND, held through wait.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stim_access <= 1'b0;
            stim_packet <= '0;
        end else if (enter_send) begin
            stim_access <= 1'b1;
            stim_packet <= ent_pkt;
        end else if (accept) begin
            stim_access <= 1'b0;
        end
    end

    // Table address advances per accept and parks on the last entry.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            addr <= '0;
        end else if (accept && !at_last) begin
            addr <= addr + AW'(1);
        end
    end

    // Accepted-packet counter, saturating at the table depth.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stim_count <= '0;
        end else if (accept && (stim_count != COUNT_MAX)) begin
            stim_count <= stim_count + (AW + 1)'(1);
        end
    end

    // Sticky completion flag, cleared only by nreset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stim_done <= 1'b0;
        end else if (enter_done) begin
            stim_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dv_stimulus.sv
// tb_dv_stimulus -- self-checking bench for dv_stimulus. A timeline model
// predicts, from the table contents and the bench's own wait pattern, the
// edge at which each access appears, its payload, the count and done flag.
module tb_dv_stimulus;

    localparam int PW    = 104;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 16;

    logic           clk       = 1'b0;
    logic           nreset    = 1'b0;
    logic           start     = 1'b0;
    logic           load_en   = 1'b0;
    logic [AW-1:0]  load_addr = '0;
    logic [PW+DW:0] load_data = '0;
    logic           stim_wait = 1'b0;
    logic           stim_access;
    logic [PW-1:0]  stim_packet;
    logic           stim_done;
    logic [AW:0]    stim_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    logic [PW-1:0] tbl_pkt [DEPTH];
    int            tbl_dly [DEPTH];
    bit            tbl_vld [DEPTH];

    dv_stimulus #(
        .PW    (PW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .stim_wait   (stim_wait),
        .stim_access (stim_access),
        .stim_packet (stim_packet),
        .stim_done   (stim_done),
        .stim_count  (stim_count)
    );

    always #5 clk = ~clk;

    // Rising edges seen since nreset was released.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        return {$urandom(), $urandom(), $urandom(), 8'($urandom())};
    endfunction

    // Extra throttle delay for an EVAL cycle that follows the k-th edge after reset.
    function automatic int throttle_add(input int k);
`ifdef CFG_STIM_THROTTLE_EN
        int s;
        int b;
        s = 'hACE1;
        for (int i = 0; i < k; i++) begin
            b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s = ((s >> 1) | (b << 15)) & 'hFFFF;
        end
        return s & 15;
`else
        return 0 * k;
`endif
    endfunction

    // Effective idle delay of entry i when its FETCH follows edge p.
    function automatic int entry_eff(input int i, input int p);
        return tbl_dly[i] + throttle_add(p + 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        start     = 1'b0;
        load_en   = 1'b0;
        stim_wait = 1'b0;
        nreset    = 1'b0;
        @(negedge clk);
        check("rst_access", stim_access, 1'b0);
        check("rst_packet", stim_packet, '0);
        check("rst_done",   stim_done,   1'b0);
        check("rst_count",  stim_count,  '0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic load_entry(input int a, input bit v, input int d, input logic [PW-1:0] pk);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = {v, DW'(d), pk};
        tbl_vld[a] = v;
        tbl_dly[a] = d;
        tbl_pkt[a] = pk;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // wait_mode: 0 never wait, 1 random wait, 2 hold each access 4 cycles.
    // stop_after>0 returns right after that many accepts.
    task automatic run_replay(input int wait_mode, input int stop_after, input bit same_edge_write,
                              output int rise_delta, output int start_edge);
        int idx, p, eff, accepted, extra, hold, n, new_dly;
        logic [AW:0]   exp_count;
        logic [PW-1:0] new_pkt;
        bit exp_access, exp_done, prev_access, prev_wait, finished;

        @(negedge clk);
        start = 1'b1;
        if (same_edge_write) begin
            new_pkt = rand_pkt();
            new_dly = $urandom_range(0, 3);
            load_en   = 1'b1;
            load_addr = '0;
            load_data = {1'b1, DW'(new_dly), new_pkt};
            tbl_vld[0] = 1'b1;
            tbl_dly[0] = new_dly;
            tbl_pkt[0] = new_pkt;
        end
        start_edge  = cyc + 1;
        p           = start_edge;
        idx         = 0;
        accepted    = 0;
        extra       = 0;
        hold        = 0;
        exp_count   = '0;
        prev_access = 1'b0;
        prev_wait   = 1'b0;
        finished    = 1'b0;
        rise_delta  = -1;
        eff         = entry_eff(0, p);

        for (int guard = 0; guard < 20000 && !finished; guard++) begin
            @(negedge clk);
            load_en = 1'b0;
            n = cyc;
            if (n == start_edge) start = 1'b0;
            if (prev_access && !prev_wait) begin
                accepted++;
                idx++;
                hold = 0;
                p = n;
                if (exp_count != (AW + 1)'(DEPTH)) exp_count++;
                if (idx < DEPTH) eff = entry_eff(idx, p);
            end
            if (idx >= DEPTH) exp_done = 1'b1;
            else              exp_done = !tbl_vld[idx] && (n >= p + 2);
            exp_access = !exp_done && (idx < DEPTH) && (n >= p + 2 + eff);

            if (stim_access === 1'b1 && rise_delta < 0) rise_delta = n - start_edge + 1;
            check("access", stim_access, exp_access);
            if (exp_access) check("packet", stim_packet, tbl_pkt[idx]);
            check("count", stim_count, exp_count);
            check("done", stim_done, exp_done);

            if (stop_after > 0 && accepted == stop_after) return;
            if (exp_done) begin
                extra++;
                start = 1'b1;
                if (extra >= 6) finished = 1'b1;
            end
            case (wait_mode)
                1: stim_wait = ($urandom_range(0, 99) < 30);
                2: begin
                    stim_wait = exp_access && (hold < 4);
                    if (stim_wait) hold++;
                end
                default: stim_wait = 1'b0;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                load_en   = 1'b1;
                load_addr = AW'($urandom_range(0, DEPTH - 1));
                load_data = (PW + DW + 1)'({$urandom(), $urandom(), $urandom(), $urandom()});
            end
            prev_access = exp_access;
            prev_wait   = stim_wait;
        end
        stim_wait = 1'b0;
        load_en   = 1'b0;
        check("replay_end", finished, 1'b1);
    endtask

    initial begin
        int rd, se, n_ent;

        do_reset();

        // Three zero-delay entries then a terminator.
        load_entry(0, 1'b1, 0, PW'(1));
        load_entry(1, 1'b1, 0, PW'(2));
        load_entry(2, 1'b1, 0, PW'(3));
        load_entry(3, 1'b0, 0, '0);
        run_replay(0, 0, 1'b0, rd, se);
        check("s1_first_rise", rd, 3 + throttle_add(se + 1));
        check("s1_count", stim_count, 3);
        check("s1_done", stim_done, 1'b1);

        // Reset after the second accept, then replay from entry 0.
        do_reset();
        run_replay(0, 2, 1'b0, rd, se);
        do_reset();
        run_replay(0, 0, 1'b0, rd, se);
        check("s5_count", stim_count, 3);

        // Single entry with delay 5.
        do_reset();
        load_entry(0, 1'b1, 5, PW'('hAB));
        load_entry(1, 1'b0, 0, '0);
        run_replay(0, 0, 1'b0, rd, se);
        check("s2_start_to_access", rd, 8 + throttle_add(se + 1));
        check("s2_count", stim_count, 1);

        // Backpressure held for 4 cycles per access.
        do_reset();
        load_entry(0, 1'b1, 2, PW'('h5A5A));
        load_entry(1, 1'b0, 0, '0);
        run_replay(2, 0, 1'b0, rd, se);
        check("s3_count", stim_count, 1);

        // Randomised tables with random backpressure.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n_ent = $urandom_range(1, 6);
            for (int i = 0; i < n_ent; i++) begin
                load_entry(i, 1'b1, $urandom_range(0, 6), rand_pkt());
            end
            load_entry(n_ent, 1'b0, $urandom_range(0, 6), rand_pkt());
            run_replay(1, 0, 1'($urandom_range(0, 1)), rd, se);
        end

        // Full table: no wrap, no access past the last entry.
        do_reset();
        for (int a = 0; a < DEPTH; a++) load_entry(a, 1'b1, 0, rand_pkt());
        run_replay(1, 0, 1'b0, rd, se);
        check("s4_count", stim_count, DEPTH);
        check("s4_done", stim_done, 1'b1);
        check("s4_no_access", stim_access, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
